// File: rtl/acia_poll_sequencer.sv
// Polling sequencer for a 2-register 6850-style ACIA: drains RX bytes into a FIFO, feeds TX bytes on TDRE.
// Optional local echo of received bytes into the TX FIFO: define ACIA_SEQ_ECHO_EN.

module acia_seq_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] head,
  output logic       empty,
  output logic       full
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr_reg;
  logic [AW:0] rd_ptr_reg;
  logic [AW:0] wr_ptr_next;
  logic [AW:0] rd_ptr_next;
  logic [7:0]  head_reg;
  logic        push_ok;
  logic        pop_ok;

  assign empty       = (wr_ptr_reg == rd_ptr_reg);
  assign full        = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                       (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign pop_ok      = pop && !empty;
  assign push_ok     = push && (!full || pop_ok);
  assign wr_ptr_next = wr_ptr_reg + {{AW{1'b0}}, push_ok};
  assign rd_ptr_next = rd_ptr_reg + {{AW{1'b0}}, pop_ok};
  assign head        = head_reg;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg[AW-1:0]] <= push_data;
    end
  end

  // Head is a registered read of the next read slot; a write into that same slot bypasses the array.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      head_reg   <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      if (push_ok && (rd_ptr_next[AW-1:0] == wr_ptr_reg[AW-1:0])) begin
        head_reg <= push_data;
      end else begin
        head_reg <= mem[rd_ptr_next[AW-1:0]];
      end
    end
  end
endmodule

module acia_poll_sequencer #(
  parameter int FIFO_DEPTH = 8,
  parameter int POLL_GAP   = 4
) (
  input  logic       clk,
  input  logic       reset,
  output logic       acia_addr,
  output logic       acia_rd,
  output logic       acia_we,
  output logic [7:0] acia_wdata,
  input  logic [7:0] acia_rdata,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       busy
);
  localparam int GAP_W = (POLL_GAP > 0) ? $clog2(POLL_GAP + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(POLL_GAP);

  typedef enum logic [2:0] {
    IDLE,
    POLL,
    SCAP,
    RXRD,
    RXCAP,
    TXWR
  } state_t;

  state_t           state_reg;
  logic [GAP_W-1:0] gap_reg;
  logic             acia_addr_reg;
  logic             acia_rd_reg;
  logic             acia_we_reg;
  logic [7:0]       acia_wdata_reg;

  logic       rx_push;
  logic       rx_pop;
  logic       rx_full;
  logic       rx_empty;
  logic       tx_push;
  logic       tx_pop;
  logic       tx_full;
  logic       tx_empty;
  logic [7:0] tx_head;
  logic [7:0] tx_push_data;
  logic       go_rx;
  logic       go_tx;
  logic       reload;

  assign acia_addr  = acia_addr_reg;
  assign acia_rd    = acia_rd_reg;
  assign acia_we    = acia_we_reg;
  assign acia_wdata = acia_wdata_reg;
  assign busy       = (state_reg != IDLE);
  assign rx_valid   = !rx_empty;

  // Status decision: RX drain first so the ACIA receiver never overruns.
  assign go_rx  = acia_rdata[0] && !rx_full;
  assign go_tx  = acia_rdata[1] && !tx_empty;
  assign reload = (state_reg == RXCAP) || (state_reg == TXWR) ||
                  ((state_reg == SCAP) && !go_rx && !go_tx);

  assign rx_push = (state_reg == RXCAP);
  assign rx_pop  = rx_valid && rx_ready;
  assign tx_pop  = (state_reg == TXWR);

`ifdef ACIA_SEQ_ECHO_EN
  logic echo_push;

  // The echo owns the TX write port during RXCAP; it is silently dropped when the TX FIFO is full.
  assign echo_push    = (state_reg == RXCAP) && !tx_full;
  assign tx_ready     = !tx_full && (state_reg != RXCAP);
  assign tx_push      = echo_push || (tx_valid && tx_ready);
  assign tx_push_data = echo_push ? acia_rdata : tx_data;
`else
  assign tx_ready     = !tx_full;
  assign tx_push      = tx_valid && tx_ready;
  assign tx_push_data = tx_data;
`endif

  acia_seq_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_rx_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (rx_push),
    .push_data(acia_rdata),
    .pop      (rx_pop),
    .head     (rx_data),
    .empty    (rx_empty),
    .full     (rx_full)
  );

  acia_seq_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_tx_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (tx_push),
    .push_data(tx_push_data),
    .pop      (tx_pop),
    .head     (tx_head),
    .empty    (tx_empty),
    .full     (tx_full)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      gap_reg        <= GAP_RELOAD;
      acia_addr_reg  <= 1'b0;
      acia_rd_reg    <= 1'b0;
      acia_we_reg    <= 1'b0;
      acia_wdata_reg <= 8'h00;
    end else begin
      acia_rd_reg <= 1'b0;
      acia_we_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (gap_reg <= GAP_W'(1)) begin
            state_reg     <= POLL;
            gap_reg       <= '0;
            acia_addr_reg <= 1'b0;
            acia_rd_reg   <= 1'b1;
          end else begin
            gap_reg <= gap_reg - GAP_W'(1);
          end
        end
        POLL: state_reg <= SCAP;
        SCAP: begin
          if (go_rx) begin
            state_reg     <= RXRD;
            acia_addr_reg <= 1'b1;
            acia_rd_reg   <= 1'b1;
          end else if (go_tx) begin
            state_reg      <= TXWR;
            acia_addr_reg  <= 1'b1;
            acia_we_reg    <= 1'b1;
            acia_wdata_reg <= tx_head;
          end
        end
        RXRD:    state_reg <= RXCAP;
        default: state_reg <= state_reg;
      endcase

      // A zero gap skips IDLE entirely so polls run back to back.
      if (reload) begin
        if (POLL_GAP == 0) begin
          state_reg     <= POLL;
          acia_addr_reg <= 1'b0;
          acia_rd_reg   <= 1'b1;
        end else begin
          state_reg <= IDLE;
          gap_reg   <= GAP_RELOAD;
        end
      end
    end
  end
endmodule

// File: tb/tb_acia_poll_sequencer.sv
// Self-checking bench for acia_poll_sequencer: behavioural ACIA model, vector table and directed corner sequences.
module tb_acia_poll_sequencer;
  localparam int DEPTH = 8;
  localparam int GAP   = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       acia_addr;
  logic       acia_rd;
  logic       acia_we;
  logic [7:0] acia_wdata;
  logic [7:0] acia_rdata = 8'h00;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic       busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  acia_poll_sequencer #(
    .FIFO_DEPTH(DEPTH),
    .POLL_GAP  (GAP)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .acia_addr (acia_addr),
    .acia_rd   (acia_rd),
    .acia_we   (acia_we),
    .acia_wdata(acia_wdata),
    .acia_rdata(acia_rdata),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .busy      (busy)
  );

  // ACIA model: RDRF is set while the bench has offered more bytes than were read.
  logic       tdre = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  int         rx_seq_in = 0;
  int         rx_seq_rd = 0;
  int         n_data_reads = 0;
  int         seq_err = 0;
  int         overlap_err = 0;
  logic       poll_seen = 1'b0;
  logic [7:0] wq[$];

  always @(posedge clk) begin
    if (acia_rd && acia_we) overlap_err <= overlap_err + 1;
    if (acia_rd) begin
      if (acia_addr) begin
        acia_rdata   <= rx_byte;
        rx_seq_rd    <= rx_seq_rd + 1;
        n_data_reads <= n_data_reads + 1;
        poll_seen    <= 1'b0;
      end else begin
        acia_rdata <= {6'b0, tdre, (rx_seq_in != rx_seq_rd)};
        poll_seen  <= 1'b1;
      end
    end
    if (acia_we) begin
      if (!acia_addr || !poll_seen) seq_err <= seq_err + 1;
      poll_seen <= 1'b0;
      wq.push_back(acia_wdata);
      $display("  acia write 0x%02h", acia_wdata);
    end
  end

  typedef struct {
    logic       is_rx;
    logic [7:0] data;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_tx(input logic [7:0] b);
    tx_data  = b;
    tx_valid = 1'b1;
    for (int t = 0; t < 100 && !tx_ready; t++) tick();
    chk("push_tx_ready", tx_ready, 1);
    tick();
    tx_valid = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b);
    rx_byte = b;
    rx_seq_in++;
  endtask

  task automatic wait_rx_valid(input string name);
    for (int t = 0; t < 300 && !rx_valid; t++) tick();
    chk(name, rx_valid, 1);
  endtask

  task automatic pop_rx(input string name, input logic [7:0] exp);
    chk(name, {rx_valid, rx_data}, {1'b1, exp});
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
  endtask

  task automatic wait_writes(input int n, input string name);
    for (int t = 0; t < 500 && wq.size() < n; t++) tick();
    chk(name, wq.size(), n);
  endtask

  task automatic wait_rxrd();
    for (int t = 0; t < 200 && !(acia_rd && acia_addr); t++) tick();
    chk("rxrd_seen", {acia_rd, acia_addr}, 2'b11);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int nd;
    vecs[0] = '{1'b0, 8'h00, 8'h00};
    vecs[1] = '{1'b1, 8'hA5, 8'hA5};
    vecs[2] = '{1'b0, 8'hFF, 8'hFF};
    vecs[3] = '{1'b1, 8'h00, 8'h00};
    vecs[4] = '{1'b0, 8'h80, 8'h80};
    vecs[5] = '{1'b1, 8'hFF, 8'hFF};
    vecs[6] = '{1'b0, 8'h7F, 8'h7F};
    vecs[7] = '{1'b1, 8'h3C, 8'h3C};

    // Reset held for two cycles.
    tick();
    tick();
    chk("reset_acia_rd", acia_rd, 0);
    chk("reset_acia_we", acia_we, 0);
    chk("reset_acia_addr", acia_addr, 0);
    chk("reset_acia_wdata", acia_wdata, 0);
    chk("reset_rx_valid", rx_valid, 0);
    chk("reset_tx_ready", tx_ready, 1);
    chk("reset_busy", busy, 0);
    reset = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (!acia_rd && n < 50);
    chk("first_poll_delay", n, GAP);
    chk("first_poll_addr", acia_addr, 0);
    chk("first_poll_busy", busy, 1);
    $display("reset: first status poll after %0d cycles", n);

    // Two TX bytes, each written after its own status poll.
    tdre = 1'b1;
    wq.delete();
    push_tx(8'h41);
    push_tx(8'h42);
    wait_writes(2, "tx_pair_count");
    if (wq.size() >= 2) begin
      chk("tx_pair_first", wq[0], 8'h41);
      chk("tx_pair_second", wq[1], 8'h42);
    end
    $display("tx pair 0x41 0x42 done");

    for (int i = 0; i < 8; i++) begin
      if (!vecs[i].is_rx) begin
        n = wq.size();
        push_tx(vecs[i].data);
        wait_writes(n + 1, "vec_tx_count");
        if (wq.size() > n) chk("vec_tx_data", wq[n], vecs[i].exp);
      end else begin
        send_rx(vecs[i].data);
        wait_rx_valid("vec_rx_valid");
        pop_rx("vec_rx_data", vecs[i].exp);
      end
      $display("vector %0d: %s 0x%02h", i, vecs[i].is_rx ? "rx" : "tx", vecs[i].data);
    end

    // RX has priority over a pending TX byte.
    tdre = 1'b0;
    wq.delete();
    push_tx(8'h31);
    repeat (20) tick();
    chk("tdre0_no_write", wq.size(), 0);
    rx_byte = 8'h5A;
    rx_seq_in++;
    tdre = 1'b1;
    wait_rx_valid("prio_rx_valid");
    chk("prio_rx_before_tx", wq.size(), 0);
    pop_rx("prio_rx_data", 8'h5A);
    wait_writes(1, "prio_tx_count");
    if (wq.size() >= 1) chk("prio_tx_data", wq[0], 8'h31);
    $display("priority: rx 0x5A then tx 0x31");

    // RX FIFO full: RDRF ignored until a slot frees.
    tdre = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      send_rx(8'h80 + 8'(i));
      for (int t = 0; t < 200 && rx_seq_rd != rx_seq_in; t++) tick();
      tick();
      tick();
    end
    chk("full_head", {rx_valid, rx_data}, {1'b1, 8'h80});
    send_rx(8'h99);
    nd = n_data_reads;
    repeat (40) tick();
    chk("full_no_data_read", n_data_reads, nd);
    pop_rx("full_pop0", 8'h80);
    for (int t = 0; t < 200 && rx_seq_rd != rx_seq_in; t++) tick();
    chk("refill_read", n_data_reads, nd + 1);
    tick();
    tick();
    chk("refill_valid", rx_valid, 1);
    for (int i = 1; i < DEPTH; i++) pop_rx("drain_data", 8'h80 + 8'(i));
    pop_rx("drain_last", 8'h99);
    chk("drained_empty", rx_valid, 0);
    $display("rx full: held byte 0x99 read after pop");

    // Reset during RXCAP discards the byte and any queued TX.
    tdre = 1'b0;
    wq.delete();
    push_tx(8'h55);
    send_rx(8'h77);
    wait_rxrd();
    tick();
    reset = 1'b1;
    tick();
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_strobes", {acia_rd, acia_we}, 2'b00);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    tick();
    chk("post_rst_strobes", {acia_rd, acia_we}, 2'b00);
    tdre = 1'b1;
    repeat (40) tick();
    chk("rst_tx_discarded", wq.size(), 0);
    chk("rst_rx_discarded", rx_valid, 0);
    $display("reset in rxcap: fifos cleared");

`ifdef ACIA_SEQ_ECHO_EN
    tdre = 1'b0;
    wq.delete();
    send_rx(8'h0D);
    wait_rxrd();
    tick();
    chk("echo_tx_ready_forced", tx_ready, 0);
    wait_rx_valid("echo_rx_valid");
    pop_rx("echo_rx_data", 8'h0D);
    tdre = 1'b1;
    wait_writes(1, "echo_tx_count");
    if (wq.size() >= 1) chk("echo_tx_data", wq[0], 8'h0D);
    $display("echo: 0x0D returned");

    tdre = 1'b0;
    wq.delete();
    for (int i = 0; i < DEPTH; i++) push_tx(8'h10 + 8'(i));
    chk("echo_tx_full", tx_ready, 0);
    send_rx(8'h0D);
    wait_rx_valid("echo_full_rx_valid");
    pop_rx("echo_full_rx_data", 8'h0D);
    tdre = 1'b1;
    wait_writes(DEPTH, "echo_full_count");
    repeat (40) tick();
    chk("echo_dropped", wq.size(), DEPTH);
    for (int i = 0; i < DEPTH && i < wq.size(); i++) chk("echo_full_order", wq[i], 8'h10 + 8'(i));
    $display("echo: dropped with tx fifo full");
`else
    tdre = 1'b0;
    wq.delete();
    send_rx(8'h0D);
    wait_rx_valid("noecho_rx_valid");
    pop_rx("noecho_rx_data", 8'h0D);
    tdre = 1'b1;
    repeat (40) tick();
    chk("noecho_no_write", wq.size(), 0);
    $display("no echo: 0x0D not returned");
`endif

    chk("poll_before_write", seq_err, 0);
    chk("rd_we_exclusive", overlap_err, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
